// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, dig_idx width helper, parameter legality check.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the digit index: max(1, clog2(n)) so a single-digit build
  // still has a one-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Legal configuration: 1 <= d <= w and w a whole number of digits.
  function automatic bit cfg_ok(input int w, input int d);
    return (d >= 1) && (d <= w) && ((w % d) == 0);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// One D-bit slice of the serial adder: sum and carry of a + b + cin.
// Latency: combinational.
// Backpressure: none.
//
// Ports: a, b (D) operand digits; cin carry in; sum (D) digit result; cout carry out.
module digit_adder #(
  parameter int D = 4
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] sum,
  output logic         cout
);

  // D+1 bit sum; the top bit is the carry into the next digit.
  logic [D:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{D{1'b0}}, cin};
  assign sum   = total[D-1:0];
  assign cout  = total[D];

endmodule

// File: rtl/serial_adder_fsm.sv
// Digit-serial W-bit add/subtract, D bits per cycle, LSB digit first.
// Latency: start at edge t -> digits in cycles t+1..t+N, done in t+N+1 (+1 with REG_OUT).
// Backpressure: none; start is only honoured in IDLE, abort cancels without done.
//
// Ports: CLK, rst (sync, active-high); start, abort, sub, A, B, CIN (sampled with start);
//        busy; S_DIG/dig_vld/dig_idx per-digit stream; SUM/COUT/OVF last result; done pulse.
module serial_adder_fsm
  import serial_add_pkg::*;
#(
  parameter int W       = 16,
  parameter int D       = 4,
  parameter int REG_OUT = 0
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         sub,
  input  logic [W-1:0]                 A,
  input  logic [W-1:0]                 B,
  input  logic                         CIN,
  output logic                         busy,
  output logic [D-1:0]                 S_DIG,
  output logic                         dig_vld,
  output logic [idx_width(W/D)-1:0]    dig_idx,
  output logic [W-1:0]                 SUM,
  output logic                         COUT,
  output logic                         OVF,
  output logic                         done
);

  localparam int N  = W / D;
  localparam int IW = idx_width(N);

  if (!cfg_ok(W, D)) begin : g_bad_cfg
    $error("serial_adder_fsm: W must be a multiple of D and 1 <= D <= W");
  end

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, acc_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    sum_q;
  logic            cout_q, ovf_q;

  logic [D-1:0]    a_dig, b_dig, dig_s;
  logic            dig_c;
  logic            last_dig, run, fin, ovf_calc;

  logic [D-1:0]    s_dig_c;
  logic            dig_vld_c, done_c, cout_c, ovf_c;
  logic [IW-1:0]   dig_idx_c;
  logic [W-1:0]    sum_c;

  // Current operand digits select by index; operands stay unshifted so the
  // sign bits are still available for overflow in DONE.
  always_comb begin
    a_dig = a_q[int'(idx_q)*D +: D];
    b_dig = b_q[int'(idx_q)*D +: D];
  end

  digit_adder #(.D(D)) u_digit_adder (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry_q),
    .sum  (dig_s),
    .cout (dig_c)
  );

  assign last_dig = (idx_q == IW'(N - 1));
  assign run      = (state_q == RUN);
  // An abort seen during DONE suppresses the completion entirely.
  assign fin      = (state_q == DONE) && !abort;
  assign ovf_calc = (a_q[W-1] == b_q[W-1]) && (acc_q[W-1] != a_q[W-1]);
  assign busy     = (state_q != IDLE);

  // State register
  always_ff @(posedge CLK) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !abort) state_d = RUN;
      RUN:     if (abort) state_d = IDLE;
               else if (last_dig) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge CLK) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            // Subtract as A + ~B + ~CIN so the same adder serves both modes.
            a_q     <= A;
            b_q     <= sub ? ~B : B;
            carry_q <= sub ? ~CIN : CIN;
            idx_q   <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            carry_q                    <= dig_c;
            acc_q[int'(idx_q)*D +: D]  <= dig_s;
            idx_q                      <= idx_q + IW'(1);
          end
        end
        DONE: begin
          if (!abort) begin
            sum_q  <= acc_q;
            cout_q <= carry_q;
            ovf_q  <= ovf_calc;
          end
        end
        default: ;
      endcase
    end
  end

  // Pre-stage outputs. During DONE the fresh result is shown directly so it
  // is valid in the same cycle as done, then held from the result registers.
  always_comb begin
    s_dig_c   = run ? dig_s : '0;
    dig_vld_c = run;
    dig_idx_c = run ? idx_q : '0;
    done_c    = fin;
    sum_c     = fin ? acc_q    : sum_q;
    cout_c    = fin ? carry_q  : cout_q;
    ovf_c     = fin ? ovf_calc : ovf_q;
  end

  if (REG_OUT != 0) begin : g_reg_out
    // Optional retiming stage; busy deliberately bypasses it.
    always_ff @(posedge CLK) begin
      if (rst) begin
        S_DIG   <= '0;
        dig_vld <= 1'b0;
        dig_idx <= '0;
        done    <= 1'b0;
        SUM     <= '0;
        COUT    <= 1'b0;
        OVF     <= 1'b0;
      end else begin
        S_DIG   <= s_dig_c;
        dig_vld <= dig_vld_c;
        dig_idx <= dig_idx_c;
        done    <= done_c;
        SUM     <= sum_c;
        COUT    <= cout_c;
        OVF     <= ovf_c;
      end
    end
  end else begin : g_comb_out
    assign S_DIG   = s_dig_c;
    assign dig_vld = dig_vld_c;
    assign dig_idx = dig_idx_c;
    assign done    = done_c;
    assign SUM     = sum_c;
    assign COUT    = cout_c;
    assign OVF     = ovf_c;
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Bench for serial_adder_fsm: W16/D4 combinational outputs, W16/D4 registered
// outputs (sharing stimulus), and W8/D8 single-digit build.
module tb_serial_adder_fsm;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst, start, abort, sub, CIN;
  logic [15:0] A, B;
  logic        start2, abort2, sub2, cin2;
  logic [7:0]  a2, b2;

  logic        busy0, vld0, cout0, ovf0, done0;
  logic [3:0]  sdig0;
  logic [1:0]  idx0;
  logic [15:0] sum0;
  logic        busy1, vld1, cout1, ovf1, done1;
  logic [3:0]  sdig1;
  logic [1:0]  idx1;
  logic [15:0] sum1;
  logic        busy2, vld2, cout2, ovf2, done2;
  logic [7:0]  sdig2;
  logic [0:0]  idx2;
  logic [7:0]  sum2;

  serial_adder_fsm #(.W(16), .D(4), .REG_OUT(0)) u0 (
    .CLK(CLK), .rst(rst), .start(start), .abort(abort), .sub(sub), .A(A), .B(B), .CIN(CIN),
    .busy(busy0), .S_DIG(sdig0), .dig_vld(vld0), .dig_idx(idx0), .SUM(sum0),
    .COUT(cout0), .OVF(ovf0), .done(done0));

  serial_adder_fsm #(.W(16), .D(4), .REG_OUT(1)) u1 (
    .CLK(CLK), .rst(rst), .start(start), .abort(abort), .sub(sub), .A(A), .B(B), .CIN(CIN),
    .busy(busy1), .S_DIG(sdig1), .dig_vld(vld1), .dig_idx(idx1), .SUM(sum1),
    .COUT(cout1), .OVF(ovf1), .done(done1));

  serial_adder_fsm #(.W(8), .D(8), .REG_OUT(0)) u2 (
    .CLK(CLK), .rst(rst), .start(start2), .abort(abort2), .sub(sub2), .A(a2), .B(b2), .CIN(cin2),
    .busy(busy2), .S_DIG(sdig2), .dig_vld(vld2), .dig_idx(idx2), .SUM(sum2),
    .COUT(cout2), .OVF(ovf2), .done(done2));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int cyc; int idx; logic [15:0] dig; } dig_t;
  typedef struct { int cyc; logic [15:0] sum; logic cout; logic ovf; } res_t;
  dig_t dq0[$], dq1[$], dq2[$];
  res_t rq0[$], rq1[$], rq2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got output %0h expected nothing (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a digit or a done.
  always @(negedge CLK) begin
    dig_t d;
    res_t r;
    if (vld0 === 1'b1) begin
      if (dq0.size() == 0) unexpected("u0_digit", {28'd0, sdig0});
      else begin
        d = dq0.pop_front();
        chk("u0_dig_cycle", cyc, d.cyc); chk("u0_dig_idx", {30'd0, idx0}, d.idx);
        chk("u0_dig", {28'd0, sdig0}, {16'd0, d.dig});
      end
    end
    if (done0 === 1'b1) begin
      if (rq0.size() == 0) unexpected("u0_done", {16'd0, sum0});
      else begin
        r = rq0.pop_front();
        chk("u0_done_cycle", cyc, r.cyc); chk("u0_sum", {16'd0, sum0}, {16'd0, r.sum});
        chk("u0_cout", {31'd0, cout0}, {31'd0, r.cout}); chk("u0_ovf", {31'd0, ovf0}, {31'd0, r.ovf});
      end
    end
    if (vld1 === 1'b1) begin
      if (dq1.size() == 0) unexpected("u1_digit", {28'd0, sdig1});
      else begin
        d = dq1.pop_front();
        chk("u1_dig_cycle", cyc, d.cyc); chk("u1_dig_idx", {30'd0, idx1}, d.idx);
        chk("u1_dig", {28'd0, sdig1}, {16'd0, d.dig});
      end
    end
    if (done1 === 1'b1) begin
      if (rq1.size() == 0) unexpected("u1_done", {16'd0, sum1});
      else begin
        r = rq1.pop_front();
        chk("u1_done_cycle", cyc, r.cyc); chk("u1_sum", {16'd0, sum1}, {16'd0, r.sum});
        chk("u1_cout", {31'd0, cout1}, {31'd0, r.cout}); chk("u1_ovf", {31'd0, ovf1}, {31'd0, r.ovf});
      end
    end
    if (vld2 === 1'b1) begin
      if (dq2.size() == 0) unexpected("u2_digit", {24'd0, sdig2});
      else begin
        d = dq2.pop_front();
        chk("u2_dig_cycle", cyc, d.cyc); chk("u2_dig_idx", {31'd0, idx2}, d.idx);
        chk("u2_dig", {24'd0, sdig2}, {16'd0, d.dig});
      end
    end
    if (done2 === 1'b1) begin
      if (rq2.size() == 0) unexpected("u2_done", {24'd0, sum2});
      else begin
        r = rq2.pop_front();
        chk("u2_done_cycle", cyc, r.cyc); chk("u2_sum", {24'd0, sum2}, {16'd0, r.sum});
        chk("u2_cout", {31'd0, cout2}, {31'd0, r.cout}); chk("u2_ovf", {31'd0, ovf2}, {31'd0, r.ovf});
      end
    end
  end

  // Push n_dig expected digits (taken from the hand-computed sum) for both
  // 16-bit instances; the registered one lags by a cycle.
  task automatic push_digits(input int n, input int n_dig, input logic [15:0] exp_sum);
    dig_t d;
    for (int k = 0; k < n_dig; k++) begin
      d.idx = k;
      d.dig = {12'd0, exp_sum[4*k +: 4]};
      d.cyc = n + 1 + k; dq0.push_back(d);
      d.cyc = n + 2 + k; dq1.push_back(d);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy0"}, {31'd0, busy0}, 0); chk({tag, "_vld0"}, {31'd0, vld0}, 0);
    chk({tag, "_done0"}, {31'd0, done0}, 0); chk({tag, "_sum0"}, {16'd0, sum0}, 0);
    chk({tag, "_cout0"}, {31'd0, cout0}, 0); chk({tag, "_ovf0"}, {31'd0, ovf0}, 0);
    chk({tag, "_busy1"}, {31'd0, busy1}, 0); chk({tag, "_vld1"}, {31'd0, vld1}, 0);
    chk({tag, "_done1"}, {31'd0, done1}, 0); chk({tag, "_sum1"}, {16'd0, sum1}, 0);
    chk({tag, "_cout1"}, {31'd0, cout1}, 0); chk({tag, "_ovf1"}, {31'd0, ovf1}, 0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s,
                        input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf,
                        input bit restart);
    int n;
    res_t r;
    A = a; B = b; CIN = ci; sub = s; start = 1'b1;
    n = cyc;
    push_digits(n, 4, exp_sum);
    r.sum = exp_sum; r.cout = exp_cout; r.ovf = exp_ovf;
    r.cyc = n + 5; rq0.push_back(r);
    r.cyc = n + 6; rq1.push_back(r);
    @(negedge CLK);
    // Scramble inputs: they must not be resampled while busy.
    start = 1'b0; A = ~a; B = ~b; CIN = ~ci; sub = ~s;
    chk("busy0_run", {31'd0, busy0}, 1); chk("busy1_run", {31'd0, busy1}, 1);
    if (restart) begin
      @(negedge CLK); start = 1'b1; A = 16'h0000; B = 16'h0000;
      @(negedge CLK); start = 1'b0;
      repeat (5) @(negedge CLK);
    end else begin
      repeat (7) @(negedge CLK);
    end
    chk("busy0_after", {31'd0, busy0}, 0); chk("busy1_after", {31'd0, busy1}, 0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic s,
                      input logic [7:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int n;
    dig_t d;
    res_t r;
    a2 = a; b2 = b; cin2 = ci; sub2 = s; start2 = 1'b1;
    n = cyc;
    d.cyc = n + 1; d.idx = 0; d.dig = {8'd0, exp_sum}; dq2.push_back(d);
    r.cyc = n + 2; r.sum = {8'd0, exp_sum}; r.cout = exp_cout; r.ovf = exp_ovf; rq2.push_back(r);
    @(negedge CLK);
    start2 = 1'b0;
    chk("busy2_run", {31'd0, busy2}, 1);
    repeat (3) @(negedge CLK);
    chk("busy2_after", {31'd0, busy2}, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; sub = 1'b0; CIN = 1'b0; A = '0; B = '0;
    start2 = 1'b0; abort2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(negedge CLK);
    check_quiet("reset");
    chk("reset_busy2", {31'd0, busy2}, 0); chk("reset_sum2", {24'd0, sum2}, 0);
    rst = 1'b0;
    @(negedge CLK);

    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

    // Abort in the second RUN cycle: digits 0 and 1 only, no done.
    A = 16'h1111; B = 16'h2222; CIN = 1'b0; sub = 1'b0; start = 1'b1;
    n = cyc;
    push_digits(n, 2, 16'h3333);
    @(negedge CLK); start = 1'b0;
    @(negedge CLK); abort = 1'b1;
    @(negedge CLK); abort = 1'b0;
    chk("abort_busy0", {31'd0, busy0}, 0); chk("abort_busy1", {31'd0, busy1}, 0);
    repeat (4) @(negedge CLK);
    chk("abort_sum0", {16'd0, sum0}, 32'h8000); chk("abort_sum1", {16'd0, sum1}, 32'h8000);

    // start together with abort in IDLE must not launch.
    start = 1'b1; abort = 1'b1;
    @(negedge CLK); start = 1'b0; abort = 1'b0;
    chk("startabort_busy0", {31'd0, busy0}, 0); chk("startabort_busy1", {31'd0, busy1}, 0);
    @(negedge CLK);

    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);

    // Reset during RUN: digit 0 (and digit 1 on the unregistered build) seen, then silence.
    A = 16'h1234; B = 16'h0FFF; CIN = 1'b0; sub = 1'b0; start = 1'b1;
    n = cyc;
    push_digits(n, 2, 16'h2233);
    void'(dq1.pop_back());
    @(negedge CLK); start = 1'b0;
    @(negedge CLK); rst = 1'b1;
    @(negedge CLK); rst = 1'b0;
    check_quiet("midrst");
    @(negedge CLK);
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0);

    // Single-digit build.
    run8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    run8(8'h34, 8'h12, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0);

    repeat (3) @(negedge CLK);
    chk("drain_dq0", dq0.size(), 0); chk("drain_rq0", rq0.size(), 0);
    chk("drain_dq1", dq1.size(), 0); chk("drain_rq1", rq1.size(), 0);
    chk("drain_dq2", dq2.size(), 0); chk("drain_rq2", rq2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
